count_seq_checker: RTL and testbench

- Receiving end of the free-running counter output: samples a W-bit count stream each valid cycle, locks onto the +1 modulo 2^W sequence, and flags deviations.
- Sits beside any counter instance, e.g. the 2-bit counter Q output, as an in-circuit monitor and self-check for the counter blocks.
- Reports lock status, per-error pulses, a saturating error count and a wrap marker.

---
 rtl/count_seq_checker.sv | 152 +++++++++++++++
 tb/tb_count_seq_checker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Locks onto a +1 (or -1 with COUNT_SEQ_CHK_DOWN_EN) modulo 2^W count stream; flags and counts deviations.
// Latency 1 (all outputs registered); no backpressure, samples taken only when in_valid=1.
module count_seq_checker #(
  parameter int W        = 2,
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 2,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  q_in,
  input  logic          in_valid,
  input  logic          err_clr,
`ifdef COUNT_SEQ_CHK_DOWN_EN
  input  logic          dir,
`endif
  output logic          locked,
  output logic          err_pulse,
  output logic          wrap_pulse,
  output logic [CW-1:0] err_count,
  output logic [W-1:0]  expected
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [3:0]   LOCK_V   = 4'(LOCK_N);
  localparam logic [3:0]   UNLOCK_V = 4'(UNLOCK_N);

  state_t        state, state_nxt;
  logic [3:0]    match_cnt, match_nxt;
  logic [3:0]    miss_cnt, miss_nxt;
  logic [W-1:0]  expected_nxt;
  logic [W-1:0]  step;
  logic [W-1:0]  wrap_val;
  logic [CW-1:0] err_count_nxt;
  logic          err_pulse_nxt, wrap_pulse_nxt;
  logic          hit, new_err;

`ifdef COUNT_SEQ_CHK_DOWN_EN
  logic dir_q;
  logic dir_chg;
  assign step     = dir ? -ONE : ONE;
  assign wrap_val = dir ? '0 : '1;
  assign dir_chg  = (dir != dir_q);
`else
  assign step     = ONE;
  assign wrap_val = '1;
`endif

  assign hit = (q_in == expected);

  always_comb begin
    state_nxt      = state;
    expected_nxt   = expected;
    match_nxt      = match_cnt;
    miss_nxt       = miss_cnt;
    err_pulse_nxt  = 1'b0;
    wrap_pulse_nxt = 1'b0;
    new_err        = 1'b0;

    if (in_valid) begin
      case (state)
        IDLE: begin
          expected_nxt = q_in + step;
          match_nxt    = '0;
          state_nxt    = ACQ;
        end
        ACQ: begin
          expected_nxt = q_in + step;
          if (hit) begin
            match_nxt = match_cnt + 4'd1;
            if (match_nxt == LOCK_V) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            expected_nxt   = expected + step;
            miss_nxt       = '0;
            wrap_pulse_nxt = (q_in == wrap_val);
          end else begin
            new_err       = 1'b1;
            err_pulse_nxt = 1'b1;
            miss_nxt      = miss_cnt + 4'd1;
            if (miss_nxt == UNLOCK_V) begin
              state_nxt    = ACQ;
              expected_nxt = q_in + step;
              match_nxt    = '0;
            end else begin
              // flywheel past a lone glitch so it costs exactly one error
              expected_nxt = expected + step;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

`ifdef COUNT_SEQ_CHK_DOWN_EN
    // direction flip invalidates the reference; reacquire without counting an error
    if (dir_chg) begin
      state_nxt      = ACQ;
      expected_nxt   = expected;
      match_nxt      = '0;
      miss_nxt       = miss_cnt;
      new_err        = 1'b0;
      err_pulse_nxt  = 1'b0;
      wrap_pulse_nxt = 1'b0;
    end
`endif

    err_count_nxt = err_count;
    if (err_clr)
      err_count_nxt = new_err ? CW'(1) : '0;
    else if (new_err && (err_count != '1))
      err_count_nxt = err_count + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      expected   <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      err_count  <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      locked     <= 1'b0;
`ifdef COUNT_SEQ_CHK_DOWN_EN
      dir_q      <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      expected   <= expected_nxt;
      match_cnt  <= match_nxt;
      miss_cnt   <= miss_nxt;
      err_count  <= err_count_nxt;
      err_pulse  <= err_pulse_nxt;
      wrap_pulse <= wrap_pulse_nxt;
      locked     <= (state_nxt == LOCKED);
`ifdef COUNT_SEQ_CHK_DOWN_EN
      dir_q      <= dir;
`endif
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker (W=2, LOCK_N=4, UNLOCK_N=2, CW=2): directed plan then random stream.
module tb_count_seq_checker;

  localparam int M      = 4;
  localparam int LOCKN  = 4;
  localparam int UNLOCK = 2;
  localparam int MAXE   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] q_in = '0;
  logic       in_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic       locked, err_pulse, wrap_pulse;
  logic [1:0] err_count, expected;

  count_seq_checker #(.W(2), .LOCK_N(LOCKN), .UNLOCK_N(UNLOCK), .CW(2)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .in_valid(in_valid), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .expected(expected)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lk;
    logic       ep;
    logic       wp;
    logic [1:0] ec;
    logic [1:0] ex;
  } obs_t;

  obs_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  // reference: mode 0=waiting for first sample, 1=acquiring, 2=locked
  int m_mode, m_exp, m_run, m_miss, m_errs;
  bit m_ep, m_wp;

  int seq_a[] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int seq_b[] = '{0, 1, 3, 3, 0, 1, 2, 3};
  int seq_c[] = '{0, 1, 3, 0, 2, 3, 0, 1, 2};

  function automatic void model_reset();
    m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0; m_errs = 0; m_ep = 0; m_wp = 0;
  endfunction

  function automatic void model_step(bit v, int q, bit clr);
    bit ne = 0;
    m_ep = 0;
    m_wp = 0;
    if (v) begin
      if (m_mode == 0) begin
        m_exp = (q + 1) % M; m_run = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        m_run = (q == m_exp) ? m_run + 1 : 0;
        m_exp = (q + 1) % M;
        if (m_run == LOCKN) begin m_mode = 2; m_miss = 0; end
      end else if (q == m_exp) begin
        m_miss = 0;
        m_wp   = (q == M - 1);
        m_exp  = (m_exp + 1) % M;
      end else begin
        ne = 1; m_ep = 1; m_miss++;
        if (m_miss == UNLOCK) begin
          m_mode = 1; m_exp = (q + 1) % M; m_run = 0;
        end else begin
          m_exp = (m_exp + 1) % M;
        end
      end
    end
    if (clr) m_errs = ne ? 1 : 0;
    else if (ne && m_errs < MAXE) m_errs++;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.lk = (m_mode == 2);
    o.ep = m_ep;
    o.wp = m_wp;
    o.ec = 2'(m_errs);
    o.ex = 2'(m_exp);
    return o;
  endfunction

  task automatic cycle(input bit r, input bit v, input int q, input bit clr);
    @(negedge clk);
    reset    = r;
    in_valid = v;
    q_in     = 2'(q);
    err_clr  = clr;
    if (r) model_reset();
    else   model_step(v, q, clr);
    sb.push_back(model_obs());
  endtask

  task automatic feed(input int q);
    cycle(1'b0, 1'b1, q, 1'b0);
  endtask

  task automatic feed_good();
    feed(m_exp);
  endtask

  task automatic feed_bad(input bit clr);
    cycle(1'b0, 1'b1, (m_exp + 2) % M, clr);
  endtask

  // monitor: one registered observation per clock edge
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{locked, err_pulse, wrap_pulse, err_count, expected};
        total++;
        ncyc++;
        if (a !== e) begin
          bad++;
          $display("FAIL cyc%0d lk/ep/wp/ec/ex got=%b/%b/%b/%0d/%0d want=%b/%b/%b/%0d/%0d",
                   ncyc, a.lk, a.ep, a.wp, a.ec, a.ex, e.lk, e.ep, e.wp, e.ec, e.ex);
        end
      end
    end
  end

  initial begin
    model_reset();
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);

    foreach (seq_a[i]) feed(seq_a[i]);   // lock on 5th sample, wrap on 8th
    foreach (seq_b[i]) feed(seq_b[i]);   // single glitch absorbed by flywheel
    foreach (seq_c[i]) feed(seq_c[i]);   // two misses unlock, then relock

    feed(3); feed(0); feed(1);
    repeat (3) cycle(1'b0, 1'b0, $urandom_range(0, 3), 1'b0);
    feed(2); feed(3);

    cycle(1'b0, 1'b0, 0, 1'b1);
    repeat (4) begin feed_bad(1'b0); feed_good(); end
    feed_bad(1'b1);
    feed_good();
    cycle(1'b0, 1'b0, 0, 1'b1);

    feed_bad(1'b0); feed_good(); feed_good();
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({locked, err_pulse, wrap_pulse, err_count, expected} !== 7'b0) begin
      bad++;
      $display("FAIL async_reset got=%b want=0", {locked, err_pulse, wrap_pulse, err_count, expected});
    end
    model_reset();
    sb.push_back(model_obs());
    cycle(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) feed(i % M);

    for (int i = 0; i < 400; i++) begin
      bit v   = ($urandom_range(0, 3) != 0);
      bit clr = ($urandom_range(0, 15) == 0);
      int q   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : m_exp;
      cycle(1'b0, v, q, clr);
    end

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
